// File: rtl/q5_fb_hazard_monitor.sv
// Clocked hazard/error monitor for the FB circuit out = (~c & ~a) | (b & c).
// Watches a settle window after each input change and reports static hazards, errors and a debounced output.
module q5_fb_hazard_monitor #(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned DEB    = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             out_dut,
    input  logic             clr,
    output logic             exp_out,
    output logic             out_filt,
    output logic             busy,
    output logic             hazard_pulse,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic             error
);

    localparam int WIN_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int DEB_W = (DEB > 1) ? $clog2(DEB) : 1;

    typedef enum logic [1:0] {ST_STABLE, ST_SETTLE, ST_REPORT} state_t;

    function automatic logic fb_f(input logic [2:0] x);
        return (~x[0] & ~x[2]) | (x[1] & x[0]);
    endfunction

    logic [2:0]       abc_q;
    logic [2:0]       abc_prev;
    logic             out_q;
    logic             primed;
    logic             chg;
    logic             f_q;
    logic             f_prev;
    logic             dev_next;

    state_t           state;
    logic [WIN_W-1:0] win;
    logic             dev;
    logic             exp_new;
    logic             is_static;
    logic [DEB_W-1:0] dcnt;

    // The priming edge loads both history stages from the live inputs so no change is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            abc_q    <= '0;
            abc_prev <= '0;
            out_q    <= 1'b0;
            primed   <= 1'b0;
        end else begin
            abc_q    <= {a, b, c};
            abc_prev <= primed ? abc_q : {a, b, c};
            out_q    <= out_dut;
            primed   <= 1'b1;
        end
    end

    assign chg      = primed && (abc_q != abc_prev);
    assign f_q      = fb_f(abc_q);
    assign f_prev   = fb_f(abc_prev);
    assign exp_out  = primed & f_q;
    assign dev_next = dev | (out_q != exp_new);
    assign busy     = (state != ST_STABLE);

    // A change always (re)opens a window, whatever the state; report actions land on the last window sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_STABLE;
            win          <= '0;
            dev          <= 1'b0;
            exp_new      <= 1'b0;
            is_static    <= 1'b0;
            hazard_pulse <= 1'b0;
            hazard_cnt   <= '0;
            error        <= 1'b0;
        end else begin
            hazard_pulse <= 1'b0;
            if (chg) begin
                state     <= ST_SETTLE;
                win       <= '0;
                dev       <= 1'b0;
                exp_new   <= f_q;
                is_static <= ((state == ST_STABLE) ? f_prev : exp_new) == f_q;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (primed && (out_q != exp_out))
                            error <= 1'b1;
                    end
                    ST_SETTLE: begin
                        dev <= dev_next;
                        if (win == WIN_W'(SETTLE - 1)) begin
                            state <= ST_REPORT;
                            if (is_static && dev_next) begin
                                hazard_pulse <= 1'b1;
                                if (hazard_cnt != '1)
                                    hazard_cnt <= hazard_cnt + 1'b1;
                            end
                            if (out_q != exp_new)
                                error <= 1'b1;
                        end else begin
                            win <= win + 1'b1;
                        end
                    end
                    ST_REPORT: state <= ST_STABLE;
                    default:   state <= ST_STABLE;
                endcase
            end
            if (clr) begin
                hazard_cnt <= '0;
                error      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_filt <= 1'b0;
            dcnt     <= '0;
        end else if (out_q == out_filt) begin
            dcnt <= '0;
        end else if (dcnt == DEB_W'(DEB - 1)) begin
            out_filt <= out_q;
            dcnt     <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_q5_fb_hazard_monitor.sv
// Bench for q5_fb_hazard_monitor: directed scenarios plus random traffic, checked every cycle
// against a history-based reference model.
module tb_q5_fb_hazard_monitor;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB    = 3;
    localparam int unsigned CNT_W  = 2;

    logic             clk = 1'b0;
    logic             rst, a, b, c, out_dut, clr;
    logic             exp_out, out_filt, busy, hazard_pulse, error;
    logic [CNT_W-1:0] hazard_cnt;

    always #5 clk = ~clk;

    q5_fb_hazard_monitor #(.SETTLE(SETTLE), .DEB(DEB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .out_dut(out_dut), .clr(clr),
        .exp_out(exp_out), .out_filt(out_filt), .busy(busy), .hazard_pulse(hazard_pulse),
        .hazard_cnt(hazard_cnt), .error(error)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    endtask

    // f written as a mux on c: c=1 -> b, c=0 -> ~a
    function automatic logic fx(input logic [2:0] v);
        return v[0] ? v[1] : ~v[2];
    endfunction

    // Reference model: per-edge history of captured samples; windows tracked by opening edge index.
    logic [2:0] habc[$];
    logic       hout[$];
    int         n = -1, wopen = -1, rep = -1, m_cnt = 0;
    logic       m_exp_new = 0, m_static = 0, m_err = 0, m_pulse = 0, m_filt = 0, m_busy = 0, m_expout = 0;

    task automatic model_edge(input logic r, input logic cl, input logic [2:0] abc, input logic o);
        logic ch, dev, alld;
        if (r) begin
            habc.delete(); hout.delete();
            n = -1; wopen = -1; rep = -1; m_cnt = 0;
            m_err = 0; m_pulse = 0; m_filt = 0; m_busy = 0; m_expout = 0;
            return;
        end
        n++;
        m_pulse = 0;
        if (n >= 1) begin
            ch = (n >= 2) && (habc[n-1] != habc[n-2]);
            if (ch) begin
                wopen = n; rep = -1;
                m_exp_new = fx(habc[n-1]);
                m_static  = (fx(habc[n-2]) == m_exp_new);
            end else if (wopen >= 0 && n == wopen + int'(SETTLE)) begin
                dev = 0;
                for (int k = wopen; k < n; k++) if (hout[k] != m_exp_new) dev = 1;
                if (m_static && dev) begin
                    m_pulse = 1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                end
                if (hout[n-1] != m_exp_new) m_err = 1;
                rep = n; wopen = -1;
            end else if (wopen < 0 && rep != n - 1) begin
                if (hout[n-1] != fx(habc[n-1])) m_err = 1;
            end
        end
        if (cl) begin m_cnt = 0; m_err = 0; end
        m_busy = (wopen >= 0) || (rep == n);
        if (n >= int'(DEB)) begin
            alld = 1;
            for (int k = n - int'(DEB); k < n; k++) if (hout[k] == m_filt) alld = 0;
            if (alld) m_filt = hout[n-1];
        end
        habc.push_back(abc);
        hout.push_back(o);
        m_expout = fx(abc);
    endtask

    task automatic cycle(input logic r, input logic [2:0] abc, input logic o, input logic cl);
        @(negedge clk);
        rst = r; {a, b, c} = abc; out_dut = o; clr = cl;
        @(posedge clk);
        model_edge(r, cl, abc, o);
        #1;
        if (hazard_pulse === 1'b1) pulses++;
        check("exp_out",      32'(exp_out),      32'(m_expout));
        check("out_filt",     32'(out_filt),     32'(m_filt));
        check("busy",         32'(busy),         32'(m_busy));
        check("hazard_pulse", 32'(hazard_pulse), 32'(m_pulse));
        check("hazard_cnt",   32'(hazard_cnt),   32'(m_cnt));
        check("error",        32'(error),        32'(m_err));
    endtask

    task automatic hold(input logic [2:0] abc, input logic o, input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, abc, o, 1'b0);
    endtask

    initial begin
        int p0, bc;
        logic [2:0] cur, prv, seq[10];
        logic o, cl, r;
        rst = 1; {a, b, c} = 3'b011; out_dut = 1; clr = 0;

        // Reset, prime, quiet hold.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'b011, 1'b1, 1'b0);
        p0 = pulses;
        hold(3'b011, 1'b1, 22);
        check("idle_pulses", 32'(pulses - p0), 32'd0);
        check("idle_exp", 32'(exp_out), 32'd1);
        check("idle_err", 32'(error), 32'd0);

        // Static-1 hazard: glitch on the 2nd window sample.
        p0 = pulses;
        cycle(1'b0, 3'b010, 1'b1, 1'b0);
        cycle(1'b0, 3'b010, 1'b1, 1'b0);
        cycle(1'b0, 3'b010, 1'b0, 1'b0);
        hold(3'b010, 1'b1, 8);
        check("static_pulse", 32'(pulses - p0), 32'd1);
        check("static_cnt", 32'(hazard_cnt), 32'd1);
        check("static_err", 32'(error), 32'd0);

        // Dynamic transitions: late-settling output is legal.
        p0 = pulses;
        hold(3'b100, 1'b0, 8);
        hold(3'b000, 1'b1, 8);
        hold(3'b001, 1'b1, 3);
        hold(3'b001, 1'b0, 8);
        check("dyn_pulse", 32'(pulses - p0), 32'd0);
        check("dyn_err", 32'(error), 32'd0);
        hold(3'b101, 1'b1, 7);
        check("func_err", 32'(error), 32'd1);
        cycle(1'b0, 3'b101, 1'b0, 1'b1);
        hold(3'b101, 1'b0, 3);
        check("clr_err", 32'(error), 32'd0);

        // Mid-window changes restart the window; busy never drops.
        seq = '{3'b100, 3'b100, 3'b101, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
        p0 = pulses; bc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, seq[i], 1'b0, 1'b0);
            if (i >= 1 && i <= 8 && busy === 1'b1) bc++;
        end
        check("busy_held", 32'(bc), 32'd8);
        check("restart_pulse", 32'(pulses - p0), 32'd0);

        // Saturation: five static-0 hazards, clr on the 5th report edge.
        p0 = pulses;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 10; i++)
                cycle(1'b0, (k % 2 == 0) ? 3'b101 : 3'b100, (i == 2), (k == 4 && i == 5));
            if (k == 3) check("sat_cnt", 32'(hazard_cnt), 32'd3);
        end
        check("sat_pulses", 32'(pulses - p0), 32'd5);
        check("sat_clr", 32'(hazard_cnt), 32'd0);

        // Debounce.
        hold(3'b100, 1'b1, 5);
        cycle(1'b0, 3'b100, 1'b0, 1'b0);
        cycle(1'b0, 3'b100, 1'b1, 1'b0);
        cycle(1'b0, 3'b100, 1'b0, 1'b0);
        cycle(1'b0, 3'b100, 1'b1, 1'b0);
        check("deb_toggle", 32'(out_filt), 32'd1);
        hold(3'b100, 1'b0, 3);
        check("deb_wait", 32'(out_filt), 32'd1);
        cycle(1'b0, 3'b100, 1'b0, 1'b1);
        check("deb_follow", 32'(out_filt), 32'd0);

        // Reset in the middle of a window.
        cycle(1'b0, 3'b101, 1'b0, 1'b0);
        cycle(1'b0, 3'b101, 1'b0, 1'b0);
        cycle(1'b0, 3'b101, 1'b1, 1'b0);
        cycle(1'b1, 3'b101, 1'b0, 1'b0);
        check("rst_busy", 32'(busy), 32'd0);
        cycle(1'b0, 3'b101, 1'b0, 1'b0);
        check("rst_pulse", 32'(hazard_pulse), 32'd0);

        // Random traffic.
        cur = 3'b101; prv = cur;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) begin prv = cur; cur = 3'($urandom_range(7)); end
            o = fx(cur);
            if ($urandom_range(3) == 0) o = fx(prv);
            if ($urandom_range(11) == 0) o = ~o;
            cl = ($urandom_range(49) == 0);
            r  = ($urandom_range(299) == 0);
            cycle(r, cur, o, cl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
